// File: rtl/cr_iu_ex_issue_ctrl.sv
// EX-stage issue controller for the IU.
// Qualifies the EX instruction, drives per-unit issue pulses, merges stall
// sources, waits on multi-cycle units and holds exceptions until CP0 acks.
// Optional feature macro: CR_IU_PERF_CNT_EN (issue/stall perf counters).
//
// state     | meaning
// ----------+-----------------------------------------------------------
// RUN       | normal issue; instructions may be selected to units
// MC_WAIT   | a multi-cycle unit was issued; waiting for its unit_done
// EXPT_HOLD | exception request held towards CP0 until cp0_iu_expt_ack
module cr_iu_ex_issue_ctrl #(
    parameter int                   NUM_UNITS  = 6,
    parameter int                   NUM_STALL  = 8,
    parameter logic [NUM_UNITS-1:0] MC_MASK    = NUM_UNITS'(2),
    parameter int                   PERF_CNT_W = 16
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst,
    input  logic                  ifu_iu_ex_inst_vld,
    input  logic                  ifu_iu_ex_rand_vld,
    input  logic                  ifu_iu_ex_expt_vld,
    input  logic                  ifu_iu_ex_prvlg_expt_vld,
    input  logic [NUM_UNITS-1:0]  decd_ctrl_unit_sel,
    input  logic                  decd_xx_unit_special_sel,
    input  logic                  decd_ctrl_expt_inv,
    input  logic                  decd_ctrl_expt_bkpt,
    input  logic                  decd_ctrl_expt_ecall,
    input  logic                  decd_ctrl_expt_wsc,
    input  logic [1:0]            cp0_yy_priv_mode,
    input  logic [NUM_STALL-1:0]  unit_stall,
    input  logic                  wb_ctrl_stall,
    input  logic [NUM_UNITS-1:0]  unit_done,
    input  logic                  cp0_iu_expt_ack,
    input  logic                  iu_xx_flush,
    output logic [NUM_UNITS-1:0]  ctrl_unit_ex_sel,
    output logic                  ctrl_special_ex_sel,
    output logic                  iu_ifu_ex_stall,
    output logic                  iu_ifu_wb_stall,
    output logic                  ctrl_mc_busy,
    output logic                  ctrl_special_expt_vld,
    output logic [4:0]            ctrl_special_expt_vec,
    output logic [PERF_CNT_W-1:0] iu_perf_issue_cnt,
    output logic [PERF_CNT_W-1:0] iu_perf_stall_cnt
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        MC_WAIT   = 2'd1,
        EXPT_HOLD = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [NUM_UNITS-1:0] mc_pend, mc_pend_nxt;
    logic                 expt_vld_nxt;
    logic [4:0]           expt_vec_nxt;
    logic [4:0]           expt_vec_sel;
    logic                 in_run;
    logic                 any_expt;
    logic                 expt_det;
    logic                 issue;
    logic [NUM_UNITS-1:0] mc_hit;

    assign in_run   = (state == RUN);
    assign any_expt = ifu_iu_ex_expt_vld | ifu_iu_ex_prvlg_expt_vld | decd_ctrl_expt_inv |
                      decd_ctrl_expt_bkpt | decd_ctrl_expt_ecall | decd_ctrl_expt_wsc;
    assign expt_det = in_run & ifu_iu_ex_inst_vld & any_expt;
    assign issue    = in_run & ifu_iu_ex_inst_vld & ~ifu_iu_ex_rand_vld & ~(|unit_stall) &
                      ~wb_ctrl_stall & ~expt_det;

    assign ctrl_unit_ex_sel    = {NUM_UNITS{issue & ~decd_xx_unit_special_sel}} & decd_ctrl_unit_sel;
    assign ctrl_special_ex_sel = issue & decd_xx_unit_special_sel;
    assign mc_hit              = ctrl_unit_ex_sel & MC_MASK;

    assign iu_ifu_wb_stall = ifu_iu_ex_inst_vld & wb_ctrl_stall;
    assign iu_ifu_ex_stall = iu_ifu_wb_stall | (|unit_stall) | ~in_run | expt_det;
    assign ctrl_mc_busy    = (state == MC_WAIT);

    // Exception vector by priority; ecall cause depends on the current privilege mode.
    always_comb begin
        expt_vec_sel = 5'd10;
        if (ifu_iu_ex_expt_vld)        expt_vec_sel = 5'd1;
        else if (decd_ctrl_expt_inv)   expt_vec_sel = 5'd2;
        else if (decd_ctrl_expt_bkpt)  expt_vec_sel = 5'd3;
        else if (decd_ctrl_expt_ecall) begin
            case (cp0_yy_priv_mode)
                2'b11:   expt_vec_sel = 5'd11;
                2'b01:   expt_vec_sel = 5'd9;
                2'b00:   expt_vec_sel = 5'd8;
                default: expt_vec_sel = 5'd0;
            endcase
        end
    end

    // Next-state logic; flush overrides every other transition in the same cycle.
    always_comb begin
        state_nxt    = state;
        mc_pend_nxt  = mc_pend;
        expt_vld_nxt = ctrl_special_expt_vld;
        expt_vec_nxt = ctrl_special_expt_vec;
        case (state)
            RUN: begin
                if (expt_det) begin
                    state_nxt    = EXPT_HOLD;
                    expt_vld_nxt = 1'b1;
                    expt_vec_nxt = expt_vec_sel;
                end else if (issue && (|mc_hit)) begin
                    state_nxt   = MC_WAIT;
                    mc_pend_nxt = mc_hit;
                end
            end
            MC_WAIT: begin
                if (|(unit_done & mc_pend)) begin
                    state_nxt   = RUN;
                    mc_pend_nxt = '0;
                end
            end
            EXPT_HOLD: begin
                if (cp0_iu_expt_ack) begin
                    state_nxt    = RUN;
                    expt_vld_nxt = 1'b0;
                end
            end
            default: state_nxt = RUN;
        endcase
        if (iu_xx_flush) begin
            state_nxt    = RUN;
            mc_pend_nxt  = '0;
            expt_vld_nxt = 1'b0;
            expt_vec_nxt = ctrl_special_expt_vec;
        end
    end

    // State, pending multi-cycle mask and exception request registers.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            state                 <= RUN;
            mc_pend               <= '0;
            ctrl_special_expt_vld <= 1'b0;
            ctrl_special_expt_vec <= 5'd0;
        end else begin
            state                 <= state_nxt;
            mc_pend               <= mc_pend_nxt;
            ctrl_special_expt_vld <= expt_vld_nxt;
            ctrl_special_expt_vec <= expt_vec_nxt;
        end
    end

`ifdef CR_IU_PERF_CNT_EN
    // Saturating issue/stall counters; only cpurst clears them, flush does not.
    always_ff @(posedge forever_cpuclk) begin
        if (cpurst) begin
            iu_perf_issue_cnt <= '0;
            iu_perf_stall_cnt <= '0;
        end else begin
            if (issue && (iu_perf_issue_cnt != '1))
                iu_perf_issue_cnt <= iu_perf_issue_cnt + 1'b1;
            if (ifu_iu_ex_inst_vld && iu_ifu_ex_stall && (iu_perf_stall_cnt != '1))
                iu_perf_stall_cnt <= iu_perf_stall_cnt + 1'b1;
        end
    end
`else
    assign iu_perf_issue_cnt = '0;
    assign iu_perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_cr_iu_ex_issue_ctrl.sv
// Directed bench for cr_iu_ex_issue_ctrl: issue, multi-cycle wait,
// exception priority/hold, stalls, flush and mid-state reset.
module tb_cr_iu_ex_issue_ctrl;

    logic        clk = 1'b0;
    logic        cpurst;
    logic        inst_vld, rand_vld, ifu_expt, prvlg;
    logic [5:0]  unit_sel;
    logic        special, inv, bkpt, ecall, wsc;
    logic [1:0]  priv;
    logic [7:0]  ustall;
    logic        wb_stall;
    logic [5:0]  done;
    logic        ack, flush;
    logic [5:0]  sel_o;
    logic        spec_sel_o, ex_stall_o, wb_stall_o, busy_o, expt_vld_o;
    logic [4:0]  vec_o;
    logic [15:0] issue_cnt_o, stall_cnt_o;

    int checks = 0;
    int errors = 0;

    cr_iu_ex_issue_ctrl dut (
        .forever_cpuclk           (clk),
        .cpurst                   (cpurst),
        .ifu_iu_ex_inst_vld       (inst_vld),
        .ifu_iu_ex_rand_vld       (rand_vld),
        .ifu_iu_ex_expt_vld       (ifu_expt),
        .ifu_iu_ex_prvlg_expt_vld (prvlg),
        .decd_ctrl_unit_sel       (unit_sel),
        .decd_xx_unit_special_sel (special),
        .decd_ctrl_expt_inv       (inv),
        .decd_ctrl_expt_bkpt      (bkpt),
        .decd_ctrl_expt_ecall     (ecall),
        .decd_ctrl_expt_wsc       (wsc),
        .cp0_yy_priv_mode         (priv),
        .unit_stall               (ustall),
        .wb_ctrl_stall            (wb_stall),
        .unit_done                (done),
        .cp0_iu_expt_ack          (ack),
        .iu_xx_flush              (flush),
        .ctrl_unit_ex_sel         (sel_o),
        .ctrl_special_ex_sel      (spec_sel_o),
        .iu_ifu_ex_stall          (ex_stall_o),
        .iu_ifu_wb_stall          (wb_stall_o),
        .ctrl_mc_busy             (busy_o),
        .ctrl_special_expt_vld    (expt_vld_o),
        .ctrl_special_expt_vec    (vec_o),
        .iu_perf_issue_cnt        (issue_cnt_o),
        .iu_perf_stall_cnt        (stall_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        inst_vld = 0; rand_vld = 0; ifu_expt = 0; prvlg = 0; unit_sel = '0;
        special = 0; inv = 0; bkpt = 0; ecall = 0; wsc = 0; priv = 2'b11;
        ustall = '0; wb_stall = 0; done = '0; ack = 0; flush = 0;
    endtask

    // {ifu_expt, prvlg, inv, bkpt, ecall, wsc}, privilege mode, expected vector
    logic [5:0] ex_flags [8] = '{6'b101100, 6'b001100, 6'b000110, 6'b000010,
                                 6'b010010, 6'b000010, 6'b010000, 6'b000001};
    logic [1:0] ex_priv  [8] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00};
    logic [4:0] ex_vec   [8] = '{5'd1, 5'd2, 5'd3, 5'd11, 5'd9, 5'd0, 5'd10, 5'd10};

    initial begin
        idle();
        cpurst = 1;
        cyc(); cyc();
        cpurst = 0;
        #1;
        chk("rst_busy", busy_o, 0);
        chk("rst_expt_vld", expt_vld_o, 0);
        chk("rst_vec", vec_o, 0);
        chk("rst_stall", ex_stall_o, 0);
        chk("rst_sel", sel_o, 0);
        chk("rst_issue_cnt", issue_cnt_o, 0);
        chk("rst_stall_cnt", stall_cnt_o, 0);

        // single-cycle unit 0 issue
        inst_vld = 1; unit_sel = 6'b000001; #1;
        chk("u0_sel", sel_o, 6'b000001);
        chk("u0_stall", ex_stall_o, 0);
        chk("u0_spec_sel", spec_sel_o, 0);
        cyc(); idle(); #1;
        chk("u0_busy_after", busy_o, 0);
        chk("u0_idle_sel", sel_o, 0);

        // special-unit issue
        inst_vld = 1; unit_sel = 6'b000010; special = 1; #1;
        chk("spec_sel", spec_sel_o, 1);
        chk("spec_unit_sel", sel_o, 0);
        cyc(); idle(); #1;
        chk("spec_no_mc", busy_o, 0);

        // multi-bit select drives all set bits
        inst_vld = 1; unit_sel = 6'b100101; #1;
        chk("multi_sel", sel_o, 6'b100101);
        cyc(); idle(); #1;

        // multi-cycle unit 1; done in the issue cycle is ignored
        inst_vld = 1; unit_sel = 6'b000010; done = 6'b000010; #1;
        chk("mc_issue_sel", sel_o, 6'b000010);
        cyc(); unit_sel = 6'b000001; done = '0; #1;
        chk("mc_c1_busy", busy_o, 1);
        chk("mc_c1_stall", ex_stall_o, 1);
        chk("mc_c1_sel", sel_o, 0);
        cyc(); done = 6'b000001; #1;
        chk("mc_c2_busy", busy_o, 1);
        cyc(); done = '0; #1;
        chk("mc_c3_busy", busy_o, 1);
        cyc(); done = 6'b000010; #1;
        chk("mc_c4_busy", busy_o, 1);
        chk("mc_c4_sel", sel_o, 0);
        cyc(); done = '0; #1;
        chk("mc_c5_busy", busy_o, 0);
        chk("mc_c5_sel", sel_o, 6'b000001);
        chk("mc_c5_stall", ex_stall_o, 0);
        cyc(); idle(); #1;

        // ecall in U mode, held until acknowledged
        inst_vld = 1; unit_sel = 6'b000001; ecall = 1; priv = 2'b00; #1;
        chk("ecall_stall", ex_stall_o, 1);
        chk("ecall_sel", sel_o, 0);
        chk("ecall_vld_pre", expt_vld_o, 0);
        cyc(); idle(); #1;
        chk("ecall_vld", expt_vld_o, 1);
        chk("ecall_vec", vec_o, 8);
        chk("ecall_hold_stall", ex_stall_o, 1);
        cyc(); #1;
        chk("ecall_vld_held", expt_vld_o, 1);
        chk("ecall_vec_held", vec_o, 8);
        ack = 1; cyc(); ack = 0; #1;
        chk("ecall_vld_clr", expt_vld_o, 0);
        chk("ecall_run_stall", ex_stall_o, 0);

        // exception priority / vector table
        for (int i = 0; i < 8; i++) begin
            idle();
            inst_vld = 1; unit_sel = 6'b000001;
            {ifu_expt, prvlg, inv, bkpt, ecall, wsc} = ex_flags[i];
            priv = ex_priv[i];
            cyc(); idle(); #1;
            chk($sformatf("prio%0d_vld", i), expt_vld_o, 1);
            chk($sformatf("prio%0d_vec", i), vec_o, ex_vec[i]);
            ack = 1; cyc(); ack = 0; #1;
            chk($sformatf("prio%0d_clr", i), expt_vld_o, 0);
        end

        // exception flags without a valid instruction are ignored
        inv = 1; #1;
        chk("noinst_stall", ex_stall_o, 0);
        cyc(); idle(); #1;
        chk("noinst_vld", expt_vld_o, 0);

        // random-insertion slot: no issue, no stall
        inst_vld = 1; rand_vld = 1; unit_sel = 6'b000001; #1;
        chk("rand_sel", sel_o, 0);
        chk("rand_stall", ex_stall_o, 0);
        // WB back-pressure
        rand_vld = 0; wb_stall = 1; #1;
        chk("wb_sel", sel_o, 0);
        chk("wb_wb_stall", wb_stall_o, 1);
        chk("wb_ex_stall", ex_stall_o, 1);
        idle(); wb_stall = 1; #1;
        chk("wb_noinst", wb_stall_o, 0);
        idle();

        // unit_stall[7] for 3 cycles, counters from a fresh reset
        cpurst = 1; cyc(); cpurst = 0;
        inst_vld = 1; unit_sel = 6'b000001; ustall = 8'h80;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("ustall%0d_sel", i), sel_o, 0);
            chk($sformatf("ustall%0d_stall", i), ex_stall_o, 1);
            cyc();
        end
        idle(); #1;
`ifdef CR_IU_PERF_CNT_EN
        chk("perf_stall_cnt", stall_cnt_o, 3);
`else
        chk("perf_stall_cnt", stall_cnt_o, 0);
`endif
        chk("perf_issue_cnt0", issue_cnt_o, 0);
        inst_vld = 1; unit_sel = 6'b000001; cyc(); idle(); #1;
`ifdef CR_IU_PERF_CNT_EN
        chk("perf_issue_cnt1", issue_cnt_o, 1);
`else
        chk("perf_issue_cnt1", issue_cnt_o, 0);
`endif

        // flush and ack together in EXPT_HOLD
        inst_vld = 1; inv = 1; cyc(); idle(); #1;
        chk("fl_hold_vld", expt_vld_o, 1);
        ack = 1; flush = 1; cyc(); idle(); #1;
        chk("fl_ack_vld", expt_vld_o, 0);
        chk("fl_ack_busy", busy_o, 0);
        chk("fl_ack_stall", ex_stall_o, 0);

        // flush beats expt_det in the same cycle
        inst_vld = 1; bkpt = 1; flush = 1; #1;
        chk("fl_det_stall", ex_stall_o, 1);
        cyc(); idle(); #1;
        chk("fl_det_vld", expt_vld_o, 0);

        // flush cycle still issues, but MC_WAIT is not entered
        inst_vld = 1; unit_sel = 6'b000010; flush = 1; #1;
        chk("fl_issue_sel", sel_o, 6'b000010);
        cyc(); idle(); #1;
        chk("fl_issue_busy", busy_o, 0);

        // flush while in MC_WAIT
        inst_vld = 1; unit_sel = 6'b000010; cyc(); idle(); #1;
        chk("fl_mc_busy", busy_o, 1);
        flush = 1; cyc(); idle(); #1;
        chk("fl_mc_busy_clr", busy_o, 0);

        // reset in MC_WAIT with a pending done
        inst_vld = 1; unit_sel = 6'b000010; cyc(); idle(); #1;
        chk("rst_mc_busy", busy_o, 1);
        cpurst = 1; done = 6'b000010; cyc(); cpurst = 0; idle(); #1;
        chk("rst_mc_busy_clr", busy_o, 0);
        chk("rst_mc_vld", expt_vld_o, 0);
        chk("rst_mc_stall", ex_stall_o, 0);

        // reset in EXPT_HOLD with a pending ack
        inst_vld = 1; bkpt = 1; cyc(); idle(); #1;
        chk("rst_ex_vec_pre", vec_o, 3);
        cpurst = 1; ack = 1; cyc(); cpurst = 0; idle(); #1;
        chk("rst_ex_vld", expt_vld_o, 0);
        chk("rst_ex_vec", vec_o, 0);
        chk("rst_ex_busy", busy_o, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
